// File: rtl/uart_tx_fifo.sv
// Byte FIFO that feeds a UART transmitter: the host pushes bytes, the FSM pops
// one at a time, pulses tx_start, and waits for tx_done before the next pop.
//
// state | meaning
// IDLE  | nothing in flight; pops the head byte when count != 0
// START | tx_start asserted for this one cycle
// WAIT  | byte in flight; leaves on tx_done
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int CW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          tx_done,
  output logic          tx_start,
  output logic [7:0]    tx_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          busy,
  output logic          ovf
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t         state;
  logic [7:0]     mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           wr_acc;
  logic           pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign busy     = (state != IDLE);
  assign tx_start = (state == START);

  // A write is refused whenever full, even if a pop frees a slot this edge.
  assign wr_acc = wr_en & ~full;
  // Pop decision uses the pre-edge count, so a byte written into an empty
  // FIFO is never read out on the same edge.
  assign pop    = (state == IDLE) & ~empty;

  // Storage is left unreset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      tx_data <= 8'h00;
      ovf     <= 1'b0;
    end else begin
      ovf <= wr_en & full;

      if (wr_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end

      case ({wr_acc, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      case (state)
        IDLE: begin
          if (pop) begin
            tx_data <= mem[rd_ptr];
            rd_ptr  <= rd_ptr + AW'(1);
            state   <= START;
          end
        end
        START: state <= WAIT;
        WAIT: begin
          if (tx_done) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo against a queue-based reference model,
// plus a loopback scoreboard of accepted bytes versus started bytes.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int CW    = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          tx_done;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          busy;
  logic          ovf;

  uart_tx_fifo #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .tx_done  (tx_done),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .busy     (busy),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: stored bytes, transfer phase (0 idle, 1 start pulse,
  // 2 waiting for done), byte presented, overflow flag.
  byte unsigned q[$];
  byte unsigned sent[$];
  int           phase;
  logic [7:0]   m_data;
  logic         m_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_vec();
    return {14'd0, tx_start, tx_data, full, empty, count, busy, ovf};
  endfunction

  function automatic logic [31:0] model_vec();
    logic [CW-1:0] c;
    c = CW'(q.size());
    return {14'd0, (phase == 1), m_data, (q.size() == DEPTH), (q.size() == 0), c,
            (phase != 0), m_ovf};
  endfunction

  task automatic model_reset();
    q.delete();
    sent.delete();
    phase  = 0;
    m_data = 8'h00;
    m_ovf  = 1'b0;
  endtask

  task automatic cycle(input logic wr, input logic [7:0] d, input logic done);
    bit m_full, m_pop, m_acc;
    wr_en   = wr;
    wr_data = d;
    tx_done = done;
    m_full = (q.size() == DEPTH);
    m_pop  = (phase == 0) && (q.size() != 0);
    m_acc  = wr && !m_full;
    m_ovf  = wr && m_full;
    if (m_pop) begin
      m_data = q.pop_front();
      phase  = 1;
    end else if (phase == 1) begin
      phase = 2;
    end else if (phase == 2 && done) begin
      phase = 0;
    end
    if (m_acc) begin
      q.push_back(d);
      sent.push_back(d);
    end
    @(posedge clk);
    @(negedge clk);
    check("cycle", dut_vec(), model_vec());
    if (tx_start) begin
      check("loopback", tx_data, (sent.size() != 0) ? 32'(sent.pop_front()) : 32'h100);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (q.size() == 0 && phase == 0) break;
      cycle(1'b0, 8'h00, (phase == 2));
    end
    check("drained", {busy, empty}, 2'b01);
  endtask

  initial begin
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    tx_done = 1'b0;
    model_reset();
    #1;
    check("reset", dut_vec(), model_vec());
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single byte
    cycle(1'b1, 8'hA5, 1'b0);
    check("a5_count_after_write", count, 1);
    cycle(1'b0, 8'h00, 1'b0);
    check("a5_start", {tx_start, tx_data}, 9'h1A5);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b0);
    check("a5_busy_waiting", busy, 1);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
    check("a5_count_end", {busy, count}, 6'h00);

    // Fill with transmitter stalled, then overflow
    for (int i = 1; i <= 16; i++) cycle(1'b1, 8'(i), 1'b0);
    check("stall_count15", count, 15);
    check("stall_inflight", tx_data, 8'h01);
    cycle(1'b1, 8'h11, 1'b0);
    check("full_flag", {full, count}, {1'b1, 5'd16});
    cycle(1'b1, 8'h12, 1'b0);
    check("ovf_pulse", {ovf, count}, {1'b1, 5'd16});
    cycle(1'b0, 8'h00, 1'b0);
    check("ovf_clear", ovf, 0);
    drain();

    // Write coinciding with a pop at count=3
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'h30 + 8'(i), 1'b0);
    check("pre_simul_count", count, 3);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'h34, 1'b0);
    check("simul_count", {tx_start, count}, {1'b1, 5'd3});

    // Reset during WAIT with count=4
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'h35, 1'b0);
    check("pre_rst_count", {busy, count}, {1'b1, 5'd4});
    rst = 1'b1;
    #1;
    model_reset();
    check("async_rst", dut_vec(), model_vec());
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'($urandom_range(0, 1)));
    check("no_start_after_rst", {tx_start, busy}, 2'b00);

    // tx_done while idle and empty
    cycle(1'b0, 8'h00, 1'b1);
    check("idle_done_ignored", {busy, tx_start, empty}, 3'b001);

    // Randomized traffic with varying write pressure
    for (int seg = 0; seg < 4; seg++) begin
      int pct;
      case (seg)
        0:       pct = 85;
        1:       pct = 30;
        2:       pct = 60;
        default: pct = 10;
      endcase
      for (int i = 0; i < 150; i++) begin
        cycle(1'($urandom_range(0, 99) < pct), 8'($urandom), 1'($urandom_range(0, 3) == 0));
      end
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
